// File: rtl/dmem_io_responder.sv
// dmem_io_responder: dmem-port splitter passing RAM accesses through and serving an I/O window (TX FIFO, RX register, cycle counter).
// Optional RX holding register is compiled in when DMEM_IO_RX_EN is defined.
module dmem_io_responder #(
  parameter int TX_DEPTH = 4,
  parameter logic [11:0] IO_BASE = 12'hF00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_dmem,
  output logic [11:0] ram_address,
  output logic [31:0] ram_data,
  output logic        ram_wren,
  input  logic [31:0] ram_q,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready
);
  localparam int AW = $clog2(TX_DEPTH);
  logic [11:0] off;
  logic io_sel, wr_tx, wr_st, wr_cyc, rd_rx, pop, push, full, ovf, rx_full;
  logic [7:0] rx_byte;
  logic [7:0] mem [TX_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic [31:0] cyc, status, q_io;
  assign io_sel = address_dmem >= IO_BASE;
  assign off = address_dmem - IO_BASE;
  assign ram_address = address_dmem;
  assign ram_data = data;
  assign ram_wren = wren & ~io_sel;
  assign wr_tx = io_sel & wren & (off == 12'd0);
  assign wr_st = io_sel & wren & (off == 12'd1);
  assign wr_cyc = io_sel & wren & (off == 12'd3);
  assign rd_rx = io_sel & ~wren & (off == 12'd2);
  assign out_valid = count != '0;
  assign out_data = out_valid ? mem[rd_ptr] : 8'h00;
  assign full = count == (AW+1)'(TX_DEPTH);
  assign pop = out_valid & out_ready;
  // a pop in the same cycle frees a slot, so a write to a full FIFO still lands
  assign push = wr_tx & (~full | pop);
  assign status = {28'b0, ovf, rx_full, ~out_valid, full};
  assign q_io = off == 12'd1 ? status : off == 12'd2 ? {24'b0, rx_byte} : off == 12'd3 ? cyc : 32'h0;
  assign q_dmem = io_sel ? q_io : ram_q;
  always_ff @(posedge clock)
    if (push) mem[wr_ptr] <= data[7:0];
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      ovf <= 1'b0;
      cyc <= 32'h0;
    end else begin
      rd_ptr <= rd_ptr + AW'(pop);
      wr_ptr <= wr_ptr + AW'(push);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      ovf <= (wr_tx & full & ~pop) ? 1'b1 : (wr_st & data[3]) ? 1'b0 : ovf;
      cyc <= wr_cyc ? data : cyc + 32'd1;
    end
`ifdef DMEM_IO_RX_EN
  // an RXDATA read only clears the register; a byte offered that cycle waits one more
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      rx_full <= 1'b0;
      rx_byte <= 8'h00;
    end else if (!rx_full) begin
      rx_full <= in_valid;
      rx_byte <= in_valid ? in_data : rx_byte;
    end else if (rd_rx) begin
      rx_full <= 1'b0;
    end
  assign in_ready = ~rx_full;
`else
  logic unused_rx;
  assign unused_rx = ^{in_data, in_valid, rd_rx};
  assign rx_full = 1'b0;
  assign rx_byte = 8'h00;
  assign in_ready = 1'b0;
`endif
endmodule

// File: tb/tb_dmem_io_responder.sv
// tb_dmem_io_responder: scoreboard bench with a queue-based reference model of the dmem I/O responder.
module tb_dmem_io_responder;
`ifdef DMEM_IO_RX_EN
  localparam bit RX = 1'b1;
`else
  localparam bit RX = 1'b0;
`endif
  localparam int DEPTH = 4;
  logic clock = 1'b0, reset = 1'b1;
  logic [11:0] address_dmem = '0, ram_address;
  logic [31:0] data = '0, q_dmem, ram_data, ram_q;
  logic wren = 1'b0, ram_wren, out_valid, out_ready = 1'b0, in_valid = 1'b0, in_ready;
  logic [7:0] out_data, in_data = '0;
  dmem_io_responder #(.TX_DEPTH(DEPTH), .IO_BASE(12'hF00)) dut (
    .clock(clock), .reset(reset), .address_dmem(address_dmem), .data(data), .wren(wren),
    .q_dmem(q_dmem), .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_q(ram_q), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready));
  always #5 clock = ~clock;
  bit [31:0] ram [4096];
  assign ram_q = ram[ram_address];
  always @(posedge clock) if (ram_wren) ram[ram_address] <= ram_data;
  typedef struct {
    logic [31:0] q; logic rw; logic ov; logic [7:0] od; logic ir; logic [11:0] ra; logic [31:0] rd;
  } exp_t;
  exp_t exp_q[$];
  int n_chk = 0, n_fail = 0;
  bit [31:0] mram [4096];
  logic [7:0] tx_q[$];
  logic m_ovf = 0, m_rxf = 0;
  logic [7:0] m_rxb = 0;
  logic [31:0] m_cyc = 0;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", n, $time, act, exp);
    end
  endtask
  always @(negedge clock) if (exp_q.size() > 0) begin
    exp_t e;
    e = exp_q.pop_front();
    chk("q_dmem", q_dmem, e.q);
    chk("ram_wren", 32'(ram_wren), 32'(e.rw));
    chk("out_valid", 32'(out_valid), 32'(e.ov));
    chk("out_data", 32'(out_data), 32'(e.od));
    chk("in_ready", 32'(in_ready), 32'(e.ir));
    chk("ram_address", 32'(ram_address), 32'(e.ra));
    chk("ram_data", ram_data, e.rd);
  end
  task automatic step(input logic [11:0] a, input logic [31:0] d, input logic w,
                      input logic ordy, input logic iv, input logic [7:0] id);
    exp_t e;
    logic io, pop, is_full;
    logic [11:0] off;
    logic [31:0] iq;
    address_dmem = a; data = d; wren = w; out_ready = ordy; in_valid = iv; in_data = id;
    io = a >= 12'hF00;
    off = a - 12'hF00;
    case (off)
      12'd1: iq = {28'b0, m_ovf, m_rxf, tx_q.size() == 0, tx_q.size() == DEPTH};
      12'd2: iq = {24'b0, m_rxb};
      12'd3: iq = m_cyc;
      default: iq = 32'h0;
    endcase
    e.q = io ? iq : mram[a];
    e.rw = w & ~io;
    e.ov = tx_q.size() > 0;
    e.od = tx_q.size() > 0 ? tx_q[0] : 8'h00;
    e.ir = RX & ~m_rxf;
    e.ra = a;
    e.rd = d;
    exp_q.push_back(e);
    @(posedge clock);
    pop = tx_q.size() > 0 && ordy;
    is_full = tx_q.size() == DEPTH;
    if (w && !io) mram[a] = d;
    if (pop) void'(tx_q.pop_front());
    if (io && w && off == 0) begin
      if (!is_full || pop) tx_q.push_back(d[7:0]);
      else m_ovf = 1'b1;
    end
    if (io && w && off == 1 && d[3]) m_ovf = 1'b0;
    if (RX) begin
      if (!m_rxf) begin
        if (iv) begin m_rxf = 1'b1; m_rxb = id; end
      end else if (io && !w && off == 2) m_rxf = 1'b0;
    end
    m_cyc = (io && w && off == 3) ? d : m_cyc + 32'd1;
    #1;
  endtask
  task automatic rd(input logic [11:0] a, input logic ordy = 1'b0);
    step(a, 32'h0, 1'b0, ordy, 1'b0, 8'h00);
  endtask
  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic ordy = 1'b0);
    step(a, d, 1'b1, ordy, 1'b0, 8'h00);
  endtask
  task automatic do_reset();
    wren = 1'b0; address_dmem = '0; in_valid = 1'b0; out_ready = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'(RX));
    @(posedge clock);
    #1;
    reset = 1'b1;
    tx_q.delete(); m_ovf = 0; m_rxf = 0; m_rxb = 0; m_cyc = 0;
  endtask
  initial begin
    #2;
    do_reset();
    rd(12'hF03);
    rd(12'hF01);
    rd(12'hF03);
    wr(12'h010, 32'h12345678);
    rd(12'h010);
    wr(12'hF03, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) wr(12'hF00, 32'h41 + i);
    rd(12'hF01);
    wr(12'hF00, 32'h45);
    rd(12'hF01);
    for (int i = 0; i < 5; i++) rd(12'hF01, 1'b1);
    wr(12'hF01, 32'h8);
    rd(12'hF01);
    for (int i = 0; i < 4; i++) wr(12'hF00, 32'hA0 + i);
    wr(12'hF00, 32'h55, 1'b1);
    rd(12'hF01, 1'b0);
    for (int i = 0; i < 6; i++) rd(12'hF01, 1'b1);
    step(12'hF01, 0, 1'b0, 1'b0, 1'b1, 8'h7E);
    rd(12'hF01);
    step(12'hF02, 0, 1'b0, 1'b0, 1'b1, 8'h33);
    rd(12'hF01);
    rd(12'hF02);
    rd(12'hF01);
    wr(12'hF03, 32'hFFFFFFFE);
    rd(12'hF03);
    rd(12'hF03);
    rd(12'hF03);
    wr(12'hF00, 32'h61);
    wr(12'hF00, 32'h62);
    do_reset();
    rd(12'hF03);
    rd(12'hF01);
    rd(12'hF03);
    for (int i = 0; i < 600; i++) begin
      logic [11:0] a;
      logic [31:0] d;
      int r;
      r = $urandom_range(0, 9);
      a = r < 4 ? 12'($urandom_range(0, 15)) : r == 9 ? 12'hFFF : 12'hF00 + 12'($urandom_range(0, 5));
      d = $urandom;
      step(a, d, $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 8'($urandom));
    end
    @(negedge clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
